// File: rtl/controlo_barreira_pkg.sv
// Shared types for the parking entry-barrier controller: plate width,
// plate type and the barrier FSM states.
package controlo_barreira_pkg;

    localparam int LARG_MATR = 24;

    typedef logic [LARG_MATR-1:0] matr_t;

    typedef enum logic {
        FECHADA = 1'b0,
        ABERTA  = 1'b1
    } estado_t;

endpackage

// File: rtl/controlo_barreira_contador_ocupacao.sv
// Saturating occupancy counter: 0..LOTACAO, never wraps. A simultaneous
// increment and decrement leaves the count unchanged.
module contador_ocupacao #(
    parameter int LOTACAO = 8
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic                           incrementa,
    input  logic                           decrementa,
    output logic [$clog2(LOTACAO+1)-1:0]   contagem,
    output logic                           cheia
);

    localparam int             CW   = $clog2(LOTACAO + 1);
    localparam logic [CW-1:0]  MAXC = CW'(LOTACAO);
    localparam logic [CW-1:0]  UM   = CW'(1);

    always_ff @(posedge clk) begin
        if (rst) begin
            contagem <= '0;
        end else if (incrementa && !decrementa && contagem != MAXC) begin
            contagem <= contagem + UM;
        end else if (decrementa && !incrementa && contagem != '0) begin
            contagem <= contagem - UM;
        end
    end

    // Decoded straight from the register so the full flag adds no latency.
    assign cheia = (contagem == MAXC);

endmodule

// File: rtl/controlo_barreira.sv
// Entry-barrier controller: admits valid plates while the park has room,
// holds the barrier open for a bounded time and keeps a two-deep plate history.
module controlo_barreira
    import controlo_barreira_pkg::*;
#(
    parameter int LOTACAO  = 8,
    parameter int T_ABERTA = 16
) (
    input  logic                           CLK,
    input  logic                           RST,
    input  logic [LARG_MATR-1:0]           Matricula,
    input  logic                           MatrVal,
    input  logic                           Pedido,
    input  logic                           Passagem,
    input  logic                           Saida,
    output logic                           Barreira,
    output logic                           LED,
    output logic                           Recusa,
    output logic [LARG_MATR-1:0]           matricula1,
    output logic [LARG_MATR-1:0]           matricula2,
    output logic [$clog2(LOTACAO+1)-1:0]   Ocupacao
);

    localparam int            TW    = (T_ABERTA > 1) ? $clog2(T_ABERTA) : 1;
    localparam logic [TW-1:0] T_FIM = TW'(T_ABERTA - 1);
    localparam logic [TW-1:0] UM    = TW'(1);

    estado_t       estado, estado_seg;
    logic [TW-1:0] temporizador;
    matr_t         pendente;
    logic          cheia;
    logic          aceita, recusa_ev, passa, expira;

    assign aceita    = (estado == FECHADA) && Pedido && MatrVal && !cheia;
    assign recusa_ev = (estado == FECHADA) && Pedido && !(MatrVal && !cheia);
    assign passa     = (estado == ABERTA) && Passagem;
    // Passagem wins over the timeout so a late vehicle is still counted.
    assign expira    = (estado == ABERTA) && !Passagem && (temporizador == T_FIM);

    always_ff @(posedge CLK) begin
        if (RST) begin
            estado <= FECHADA;
        end else begin
            estado <= estado_seg;
        end
    end

    always_comb begin
        estado_seg = estado;
        case (estado)
            FECHADA: if (aceita)          estado_seg = ABERTA;
            ABERTA:  if (passa || expira) estado_seg = FECHADA;
            default:                      estado_seg = FECHADA;
        endcase
    end

    always_comb begin
        Barreira = (estado == ABERTA);
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            Recusa       <= 1'b0;
            temporizador <= '0;
            pendente     <= '0;
            matricula1   <= '0;
            matricula2   <= '0;
        end else begin
            Recusa <= recusa_ev;
            if (aceita) begin
                pendente     <= Matricula;
                temporizador <= '0;
            end else if (estado == ABERTA) begin
                temporizador <= temporizador + UM;
            end
            if (passa) begin
                matricula2 <= matricula1;
                matricula1 <= pendente;
            end
        end
    end

    contador_ocupacao #(
        .LOTACAO (LOTACAO)
    ) u_ocupacao (
        .clk        (CLK),
        .rst        (RST),
        .incrementa (passa),
        .decrementa (Saida),
        .contagem   (Ocupacao),
        .cheia      (cheia)
    );

    assign LED = cheia;

endmodule

// File: tb/tb_controlo_barreira.sv
// Bench for controlo_barreira: directed scenarios with literal expectations,
// then random traffic, all checked every cycle against a behavioural model.
module tb_controlo_barreira;

    localparam int LOT = 2;
    localparam int TA  = 4;

    logic        CLK = 1'b0;
    logic        RST = 1'b1;
    logic [23:0] Matricula = '0;
    logic        MatrVal = 1'b0;
    logic        Pedido = 1'b0;
    logic        Passagem = 1'b0;
    logic        Saida = 1'b0;
    logic        Barreira, LED, Recusa;
    logic [23:0] matricula1, matricula2;
    logic [1:0]  Ocupacao;

    int n_chk  = 0;
    int n_fail = 0;
    bit chk_on = 1'b0;

    // Model: barrier open flag, cycles spent open, plates, occupancy.
    bit          m_open = 0;
    int          m_cyc  = 0;
    logic [23:0] m_pend = '0, m_h1 = '0, m_h2 = '0;
    int          m_occ  = 0;
    bit          m_rec  = 0;

    controlo_barreira #(.LOTACAO(LOT), .T_ABERTA(TA)) dut (
        .CLK        (CLK),
        .RST        (RST),
        .Matricula  (Matricula),
        .MatrVal    (MatrVal),
        .Pedido     (Pedido),
        .Passagem   (Passagem),
        .Saida      (Saida),
        .Barreira   (Barreira),
        .LED        (LED),
        .Recusa     (Recusa),
        .matricula1 (matricula1),
        .matricula2 (matricula2),
        .Ocupacao   (Ocupacao)
    );

    always #5 CLK = ~CLK;

    task automatic chk(input string nome, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", nome, act, exp, $time);
        end
    endtask

    always @(posedge CLK) begin
        bit inc;
        inc = 0;
        if (RST) begin
            m_open = 0; m_cyc = 0; m_pend = '0; m_h1 = '0; m_h2 = '0;
            m_occ = 0; m_rec = 0;
        end else begin
            m_rec = 0;
            if (!m_open) begin
                if (Pedido) begin
                    if (MatrVal && m_occ < LOT) begin
                        m_open = 1; m_cyc = 1; m_pend = Matricula;
                    end else begin
                        m_rec = 1;
                    end
                end
            end else if (Passagem) begin
                m_open = 0; inc = 1; m_h2 = m_h1; m_h1 = m_pend;
            end else if (m_cyc == TA) begin
                m_open = 0;
            end else begin
                m_cyc++;
            end
            if (inc && !Saida) m_occ = (m_occ < LOT) ? m_occ + 1 : m_occ;
            else if (Saida && !inc && m_occ > 0) m_occ = m_occ - 1;
        end
    end

    always @(negedge CLK) begin
        if (chk_on) begin
            chk("barreira",   32'(Barreira),   32'(m_open));
            chk("recusa",     32'(Recusa),     32'(m_rec));
            chk("ocupacao",   32'(Ocupacao),   32'(m_occ));
            chk("led",        32'(LED),        32'(m_occ == LOT));
            chk("matricula1", 32'(matricula1), 32'(m_h1));
            chk("matricula2", 32'(matricula2), 32'(m_h2));
        end
    end

    task automatic drive(input logic rst, input logic ped, input logic val,
                         input logic [23:0] m, input logic pas, input logic sai);
        @(negedge CLK);
        RST = rst; Pedido = ped; MatrVal = val; Matricula = m;
        Passagem = pas; Saida = sai;
    endtask

    task automatic idle();
        drive(0, 0, 0, 24'h0, 0, 0);
    endtask

    initial begin
        int altos;
        drive(1, 0, 0, 24'h0, 0, 0);
        drive(1, 0, 0, 24'h0, 0, 0);
        chk_on = 1'b1;
        idle();
        chk("rst_barreira", 32'(Barreira), 32'd0);
        chk("rst_ocupacao", 32'(Ocupacao), 32'd0);
        chk("rst_m1",       32'(matricula1), 32'd0);

        // Admit
        drive(0, 1, 1, 24'h34A366, 0, 0);
        idle();
        chk("admit_open", 32'(Barreira), 32'd1);
        idle();
        drive(0, 0, 0, 24'h0, 1, 0);
        idle();
        chk("admit_closed", 32'(Barreira), 32'd0);
        chk("admit_occ",    32'(Ocupacao), 32'd1);
        chk("admit_m1",     32'(matricula1), 32'h34A366);
        chk("admit_m2",     32'(matricula2), 32'h000000);

        // Fill
        drive(0, 1, 1, 24'hBBABFF, 0, 0);
        idle();
        drive(0, 0, 0, 24'h0, 1, 0);
        idle();
        chk("fill_m1",  32'(matricula1), 32'hBBABFF);
        chk("fill_m2",  32'(matricula2), 32'h34A366);
        chk("fill_occ", 32'(Ocupacao), 32'd2);
        chk("fill_led", 32'(LED), 32'd1);
        drive(0, 1, 1, 24'h123468, 0, 0);
        idle();
        chk("full_recusa",   32'(Recusa), 32'd1);
        chk("full_barreira", 32'(Barreira), 32'd0);
        idle();
        chk("full_recusa_end", 32'(Recusa), 32'd0);

        // Timeout
        drive(0, 0, 0, 24'h0, 0, 1);
        idle();
        chk("saida_occ", 32'(Ocupacao), 32'd1);
        chk("saida_led", 32'(LED), 32'd0);
        drive(0, 1, 1, 24'hBD9752, 0, 0);
        altos = 0;
        for (int i = 0; i < 8; i++) begin
            idle();
            if (Barreira) altos++;
        end
        chk("timeout_cycles", 32'(altos), 32'd4);
        chk("timeout_occ",    32'(Ocupacao), 32'd1);
        chk("timeout_m1",     32'(matricula1), 32'hBBABFF);

        // Invalid plate, then Pedido while open
        drive(0, 1, 0, 24'hFD9D52, 0, 0);
        idle();
        chk("inval_recusa",   32'(Recusa), 32'd1);
        chk("inval_barreira", 32'(Barreira), 32'd0);
        drive(0, 1, 1, 24'hA1B2C3, 0, 0);
        drive(0, 1, 1, 24'h999999, 0, 0);
        idle();
        chk("open_ped_recusa", 32'(Recusa), 32'd0);

        // Passagem with Saida at occupancy 1
        drive(0, 0, 0, 24'h0, 1, 1);
        idle();
        chk("pas_sai_occ", 32'(Ocupacao), 32'd1);
        chk("pas_sai_m1",  32'(matricula1), 32'hA1B2C3);

        // Saida at zero
        drive(0, 0, 0, 24'h0, 0, 1);
        idle();
        chk("sai_to0", 32'(Ocupacao), 32'd0);
        drive(0, 0, 0, 24'h0, 0, 1);
        idle();
        chk("sai_at0", 32'(Ocupacao), 32'd0);

        // Passagem on the final open cycle
        drive(0, 1, 1, 24'h0C0FFE, 0, 0);
        idle(); idle(); idle();
        drive(0, 0, 0, 24'h0, 1, 0);
        idle();
        chk("late_pas_occ", 32'(Ocupacao), 32'd1);
        chk("late_pas_m1",  32'(matricula1), 32'h0C0FFE);

        // Reset while open
        drive(0, 1, 1, 24'h777777, 0, 0);
        idle();
        drive(1, 0, 0, 24'h0, 0, 0);
        idle();
        chk("rst_open_barreira", 32'(Barreira), 32'd0);
        chk("rst_open_occ",      32'(Ocupacao), 32'd0);
        chk("rst_open_m1",       32'(matricula1), 32'd0);
        chk("rst_open_m2",       32'(matricula2), 32'd0);
        chk("rst_open_led",      32'(LED), 32'd0);

        // Random traffic
        for (int i = 0; i < 3000; i++) begin
            drive($urandom_range(0, 99) < 1,
                  $urandom_range(0, 99) < 30,
                  $urandom_range(0, 99) < 75,
                  24'($urandom),
                  $urandom_range(0, 99) < 30,
                  $urandom_range(0, 99) < 20);
        end
        idle();
        idle();

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
